// File: rtl/pb_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pb_intr_ctrl
//  Description : Interrupt controller for the kcpsm6 single interrupt line.
//                Merges three external edge sources and a periodic timer into
//                one interrupt/interrupt_ack handshake. Each source has a
//                pending latch and a mask bit. Fixed priority: lowest index
//                wins. An EOI write ends each service.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_intr_ctrl #(
    parameter int SIMULATE      = 0,
    parameter int TIMER_DIV     = 5000000,
    parameter int TIMER_DIV_SIM = 50
) (
    input  logic       sysclk,
    input  logic       sysreset_n,
    input  logic [2:0] irq_src,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [7:0] int_cause,
    output logic [3:0] int_mask,
    output logic       timer_tick
);

    localparam int DIV = (SIMULATE != 0) ? TIMER_DIV_SIM : TIMER_DIV;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_CLRPEND = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_EOI     = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    src_prev;
    logic [3:0]    pending;
    logic [3:0]    mask;
    logic          timer_en;
    logic [CW-1:0] tcount;
    logic [1:0]    id;
    logic          busy;

    logic          wr_mask;
    logic          wr_clr;
    logic          wr_ctrl;
    logic          wr_eoi;
    logic          restart;
    logic          wrap;
    logic          ack_take;
    logic [3:0]    clr_bits;
    logic [3:0]    set_bits;
    logic [3:0]    pend_next;
    logic [3:0]    req;
    logic [1:0]    prio_id;
    logic          unused_cfg_bits;

    assign wr_mask  = cfg_wr && (cfg_addr == ADDR_MASK);
    assign wr_clr   = cfg_wr && (cfg_addr == ADDR_CLRPEND);
    assign wr_ctrl  = cfg_wr && (cfg_addr == ADDR_CTRL);
    assign wr_eoi   = cfg_wr && (cfg_addr == ADDR_EOI);

    // A counter restart takes precedence over a wrap in the same cycle, so a
    // restart never produces a tick of its own.
    assign restart  = wr_ctrl && cfg_data[1];
    assign wrap     = timer_en && !restart && (tcount == LAST);

    assign ack_take = (state == ASSERT) && interrupt_ack;
    assign clr_bits = (wr_clr ? cfg_data[3:0] : 4'h0)
                    | (ack_take ? (4'b0001 << id) : 4'h0);
    assign set_bits = {wrap, irq_src & ~src_prev};
    // Set wins over clear when both hit the same bit in one cycle.
    assign pend_next = (pending & ~clr_bits) | set_bits;

    assign req = pending & mask;

    assign int_cause = {busy, 1'b0, id, pending};
    assign int_mask  = mask;

    assign unused_cfg_bits = ^cfg_data[7:4];

    // Fixed priority encoder: source 0 is the most urgent.
    always_comb begin
        prio_id = 2'd3;
        if (req[0]) begin
            prio_id = 2'd0;
        end else if (req[1]) begin
            prio_id = 2'd1;
        end else if (req[2]) begin
            prio_id = 2'd2;
        end
    end

    // Edge detection, pending latches, mask and timer control registers.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            src_prev <= 3'b000;
            pending  <= 4'h0;
            mask     <= 4'h0;
            timer_en <= 1'b0;
        end else begin
            src_prev <= irq_src;
            pending  <= pend_next;
            if (wr_mask) begin
                mask <= cfg_data[3:0];
            end
            if (wr_ctrl) begin
                timer_en <= cfg_data[0];
            end
        end
    end

    // Periodic timer: counts 0..DIV-1 while enabled and pulses on wrap.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            tcount     <= '0;
            timer_tick <= 1'b0;
        end else begin
            timer_tick <= wrap;
            if (restart || wrap) begin
                tcount <= '0;
            end else if (timer_en) begin
                tcount <= tcount + CW'(1);
            end
        end
    end

    // Service handshake: request -> ack -> EOI, with registered outputs.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            id        <= 2'd0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 4'h0) begin
                        id        <= prio_id;
                        interrupt <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (interrupt_ack) begin
                        interrupt <= 1'b0;
                        state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    interrupt <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_intr_ctrl
//  Description : Self-checking bench for pb_intr_ctrl. Directed scenarios
//                plus randomized traffic compared against a behavioural
//                model of the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_intr_ctrl;

    localparam int DIV = 50;

    logic       sysclk;
    logic       sysreset_n;
    logic [2:0] irq_src;
    logic       cfg_wr;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       interrupt;
    logic       interrupt_ack;
    logic [7:0] int_cause;
    logic [3:0] int_mask;
    logic       timer_tick;

    int total;
    int bad;

    // behavioural model state
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [2:0] m_prev;
    bit       m_int;
    int       m_phase;     // 0 waiting for a request, 1 waiting for ack, 2 waiting for EOI
    int       m_id;
    bit       m_ten;
    int       m_elapsed;   // enabled cycles since last restart
    bit       m_tick;

    pb_intr_ctrl #(
        .SIMULATE      (1),
        .TIMER_DIV     (5000000),
        .TIMER_DIV_SIM (DIV)
    ) dut (
        .sysclk        (sysclk),
        .sysreset_n    (sysreset_n),
        .irq_src       (irq_src),
        .cfg_wr        (cfg_wr),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .int_cause     (int_cause),
        .int_mask      (int_mask),
        .timer_tick    (timer_tick)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_prev = 0; m_int = 0; m_phase = 0;
        m_id = 0; m_ten = 0; m_elapsed = 0; m_tick = 0;
    endtask

    // Advance the model by one clock using the inputs applied for that cycle.
    task automatic model_step(input bit [2:0] irq, input bit wr, input bit [1:0] addr,
                              input bit [7:0] data, input bit ack);
        bit [3:0] setb;
        bit [3:0] clrb;
        bit [3:0] req;
        setb = 0;
        clrb = 0;
        m_tick = 0;
        if (wr && addr == 2 && data[1]) begin
            m_elapsed = 0;
        end else if (m_ten) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed % DIV == 0) m_tick = 1;
        end
        for (int i = 0; i < 3; i++)
            if (irq[i] && !m_prev[i]) setb[i] = 1;
        setb[3] = m_tick;
        m_prev = irq;
        if (wr && addr == 1) clrb = data[3:0];
        req = m_pend & m_mask;
        if (m_phase == 0 && req != 0) begin
            for (int i = 3; i >= 0; i--)
                if (req[i]) m_id = i;
            m_int = 1;
            m_phase = 1;
        end else if (m_phase == 1 && ack) begin
            m_int = 0;
            clrb[m_id] = 1;
            m_phase = 2;
        end else if (m_phase == 2 && wr && addr == 3) begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~clrb) | setb;
        if (wr && addr == 0) m_mask = data[3:0];
        if (wr && addr == 2) m_ten = data[0];
    endtask

    task automatic compare_all();
        bit [1:0] idb;
        idb = 2'(m_id);
        check("interrupt", {31'd0, interrupt}, {31'd0, m_int});
        check("int_cause", {24'd0, int_cause}, {24'd0, (m_phase != 0), 1'b0, idb, m_pend});
        check("int_mask", {28'd0, int_mask}, {28'd0, m_mask});
        check("timer_tick", {31'd0, timer_tick}, {31'd0, m_tick});
    endtask

    // One clock: drive at falling edge, update model, sample 1 ns after rising edge.
    task automatic cyc(input logic [2:0] irq, input logic wr, input logic [1:0] addr,
                       input logic [7:0] data, input logic ack);
        @(negedge sysclk);
        irq_src = irq; cfg_wr = wr; cfg_addr = addr; cfg_data = data; interrupt_ack = ack;
        model_step(irq, wr, addr, data, ack);
        @(posedge sysclk);
        #1;
        compare_all();
    endtask

    // Timer run with automatic ack/EOI; returns the cycle index of the first tick.
    task automatic timer_run(input int n, output int first);
        first = -1;
        for (int k = 1; k <= n; k++) begin
            cyc(3'b000, (m_phase == 2), 2'd3, 8'h00, m_int);
            if (timer_tick && first < 0) first = k;
        end
    endtask

    initial begin
        int first;
        total = 0;
        bad   = 0;
        sysreset_n = 1'b0;
        irq_src = 0; cfg_wr = 0; cfg_addr = 0; cfg_data = 0; interrupt_ack = 0;
        model_reset();
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_interrupt", {31'd0, interrupt}, 32'd0);
        check("rst_int_cause", {24'd0, int_cause}, 32'h00);
        check("rst_int_mask", {28'd0, int_mask}, 32'h0);
        check("rst_timer_tick", {31'd0, timer_tick}, 32'd0);
        @(negedge sysclk);
        sysreset_n = 1'b1;

        // basic service of source 0
        cyc(3'b000, 1, 2'd0, 8'h01, 0);
        cyc(3'b001, 0, 2'd0, 8'h00, 0);
        check("t2_not_yet", {31'd0, interrupt}, 32'd0);
        cyc(3'b001, 0, 2'd0, 8'h00, 0);
        check("t2_latency", {31'd0, interrupt}, 32'd1);
        cyc(3'b001, 0, 2'd0, 8'h00, 1);
        check("t2_cause_ack", {24'd0, int_cause}, 32'h80);
        cyc(3'b000, 1, 2'd3, 8'h00, 0);
        check("t2_eoi_busy", {31'd0, int_cause[7]}, 32'd0);

        // masked pending, then unmask
        cyc(3'b000, 1, 2'd0, 8'h00, 0);
        cyc(3'b010, 0, 2'd0, 8'h00, 0);
        cyc(3'b000, 0, 2'd0, 8'h00, 0);
        check("t3_pend1", {31'd0, int_cause[1]}, 32'd1);
        check("t3_masked", {31'd0, interrupt}, 32'd0);
        cyc(3'b000, 1, 2'd0, 8'h02, 0);
        cyc(3'b000, 0, 2'd0, 8'h00, 0);
        check("t3_unmask_int", {31'd0, interrupt}, 32'd1);
        check("t3_id", {30'd0, int_cause[5:4]}, 32'd1);
        cyc(3'b000, 0, 2'd0, 8'h00, 1);
        cyc(3'b000, 1, 2'd3, 8'h00, 0);

        // simultaneous sources 0 and 2
        cyc(3'b000, 1, 2'd0, 8'h0F, 0);
        cyc(3'b101, 0, 2'd0, 8'h00, 0);
        cyc(3'b101, 0, 2'd0, 8'h00, 0);
        cyc(3'b101, 0, 2'd0, 8'h00, 1);
        check("t4_pend_after_ack", {28'd0, int_cause[3:0]}, 32'h4);
        check("t4_first_id", {30'd0, int_cause[5:4]}, 32'd0);
        cyc(3'b101, 1, 2'd3, 8'h00, 0);
        cyc(3'b000, 0, 2'd0, 8'h00, 0);
        check("t4_second_id", {30'd0, int_cause[5:4]}, 32'd2);
        cyc(3'b000, 0, 2'd0, 8'h00, 1);
        cyc(3'b000, 1, 2'd3, 8'h00, 0);

        // edge of source 0 coinciding with its ack, then reset while asserted
        cyc(3'b000, 1, 2'd0, 8'h01, 0);
        cyc(3'b001, 0, 2'd0, 8'h00, 0);
        cyc(3'b001, 0, 2'd0, 8'h00, 0);
        cyc(3'b000, 0, 2'd0, 8'h00, 0);
        cyc(3'b001, 0, 2'd0, 8'h00, 1);
        check("t6_setwins", {31'd0, int_cause[0]}, 32'd1);
        cyc(3'b001, 1, 2'd3, 8'h00, 0);
        cyc(3'b001, 0, 2'd0, 8'h00, 0);
        check("t6_reassert", {31'd0, interrupt}, 32'd1);
        sysreset_n = 1'b0;
        #1;
        check("t6_async_rst_int", {31'd0, interrupt}, 32'd0);
        check("t6_async_rst_cause", {24'd0, int_cause}, 32'h00);
        model_reset();
        @(negedge sysclk);
        sysreset_n = 1'b1;
        irq_src = 0;

        // timer period and restart
        cyc(3'b000, 1, 2'd0, 8'h08, 0);
        cyc(3'b000, 1, 2'd2, 8'h01, 0);
        timer_run(DIV, first);
        check("t5_first_tick", first, DIV);
        timer_run(DIV, first);
        check("t5_period", first, DIV);
        timer_run(20, first);
        cyc(3'b000, 1, 2'd2, 8'h03, 0);
        timer_run(DIV, first);
        check("t5_restart", first, DIV);
        cyc(3'b000, 1, 2'd2, 8'h00, 0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [2:0] irq;
            logic       wr;
            logic [1:0] addr;
            logic [7:0] data;
            logic       ack;
            irq = irq_src;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(7) == 0) irq[b] = ~irq[b];
            wr   = ($urandom_range(4) == 0);
            addr = 2'($urandom_range(3));
            if (addr == 2'd2 && $urandom_range(5) != 0) addr = 2'd3;
            data = 8'($urandom);
            if (addr == 2'd2 && $urandom_range(3) != 0) data[1] = 1'b0;
            ack  = ($urandom_range(3) == 0);
            cyc(irq, wr, addr, data, ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
